// File: rtl/dff_fifo.sv
// Flop-based first-word-fall-through FIFO with valid/ready on both sides.
// Define DFF_FIFO_OVERFLOW_FLAG_EN to build the sticky overflow flag.
module dff_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, empty;
  logic             push, pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

`ifdef DFF_FIFO_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  // A write attempt while full is a drop, even if a pop frees space.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dff_fifo.sv
// Directed bench for dff_fifo: stimulus queues expected words,
// a negedge monitor checks every popped word in order.
module tb_dff_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q [$];

`ifdef DFF_FIFO_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  dff_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic expect_it);
    in_data  = d;
    in_valid = 1'b1;
    if (expect_it) exp_q.push_back(d);
    tick();
  endtask

  // Monitor: a pop happens at the next posedge when valid&ready here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {24'h0, out_data}, 32'hDEAD);
      end else begin
        check("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b0;

    // Reset / idle
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_overflow", overflow, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post_rst_count", count, 0);

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      push_word(8'hA1 + 8'(i), 1'b1);
      check("fill_count", count, i + 1);
    end
    in_valid = 1'b0;
    check("fill_in_ready", in_ready, 0);
    check("fill_out_valid", out_valid, 1);
    check("fill_head", out_data, 8'hA1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", count, 3 - i);
    end
    check("drain_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // Overflow: 55 must be dropped
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    push_word(8'h55, 1'b0);
    in_valid = 1'b0;
    check("ovf_count", count, 4);
    check("ovf_head", out_data, 8'h11);
    check("ovf_flag", overflow, OVF_EXP);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("ovf_drain_count", count, 0);
    check("ovf_flag_sticky", overflow, OVF_EXP);
    tick();
    check("ovf_flag_idle", overflow, OVF_EXP);

    // Simultaneous push/pop at count=2
    push_word(8'h61, 1'b1);
    push_word(8'h62, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_word(8'h01 + 8'(i), 1'b1);
      check("simul_count", count, 2);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("simul_drain_count", count, 0);
    out_ready = 1'b0;

    // Wrap-around: 00..09 with occupancy 0..3
    for (int i = 0; i < 10; i++) begin
      out_ready = (i >= 3);
      push_word(8'(i), 1'b1);
      check("wrap_count", count, (i < 3) ? i + 1 : 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("wrap_drain_count", count, 0);
    check("wrap_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // Asynchronous reset mid-stream discards 71..73
    push_word(8'h71, 1'b0);
    push_word(8'h72, 1'b0);
    push_word(8'h73, 1'b0);
    in_valid = 1'b0;
    check("pre_arst_count", count, 3);
    #1 rst_n = 1'b0;
    #2;
    check("arst_count", count, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_overflow", overflow, 0);
    #3 rst_n = 1'b1;
    tick();
    check("arst_idle_count", count, 0);
    push_word(8'hEE, 1'b1);
    in_valid = 1'b0;
    check("arst_head", out_data, 8'hEE);
    check("arst_push_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("arst_final_count", count, 0);

    tick();
    check("leftover_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_fifo.md
Name: dff_fifo

Overview:
- Small synchronous FIFO whose storage is a flat bank of flip-flop registers, DEPTH words of WIDTH bits.
- Sits directly downstream of the single-bit dff storage element in the memory library.
- Buffers words between a producer and a consumer using valid/ready handshakes on both sides.
- Read side is first-word fall-through: head word is visible on out_data whenever out_valid=1.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage words; must be a power of two, >=2
AW, $clog2(DEPTH), pointer width; derived, not to be overridden

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  write word
in_valid  input  1  producer offers in_data
in_ready  output  1  FIFO can accept; equals !full
out_data  output  WIDTH  head word (mem[rd_ptr])
out_valid  output  1  FIFO holds >=1 word; equals !empty
out_ready  input  1  consumer takes head word
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously clears wr_ptr, rd_ptr, count, overflow and all storage words to 0. While in reset: in_ready=1, out_valid=0, out_data=0, count=0. Release is sampled on the next rising clk.
- Push when in_valid && in_ready at a rising edge: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1 mod DEPTH.
- Pop when out_valid && out_ready at a rising edge: rd_ptr <= rd_ptr+1 mod DEPTH. Storage is not cleared on pop.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- full = (count==DEPTH); empty = (count==0). in_ready and out_valid are combinational from count only, never from in_valid or out_ready.
- Latency: a word pushed at edge N gives out_valid=1 and out_data=that word after edge N (visible in cycle N+1) when the FIFO was empty. No bypass path: a push into an empty FIFO is never visible in the same cycle.
- Simultaneous push and pop:
  - 0 < count < DEPTH: both occur, count unchanged.
  - Full: in_ready=0, so only the pop occurs; count -> DEPTH-1.
  - Empty: out_valid=0, so only the push occurs; count -> 1.
- Wrap-around: pointers wrap modulo DEPTH; ordering is strict FIFO across wrap.
- in_valid while full: word dropped, no state change except overflow (if enabled).
- out_ready while empty: ignored, no state change.
- out_data while empty: holds mem[rd_ptr], a stale or reset value; consumers qualify with out_valid.
- X on in_data is stored as-is; X on in_valid or out_ready is not permitted.
- Reset mid-operation: all contents are discarded immediately (asynchronous); the first word after release is the first one pushed.

Optional Feature:
- Macro DFF_FIFO_OVERFLOW_FLAG_EN.
- Defined: overflow sets to 1 at the rising edge where in_valid=1 and full=1, and stays 1 until rst_n is asserted. It is not set when a pop frees space in the same cycle, because in_ready is already 0 and the attempt is a drop.
- Undefined: overflow is tied to constant 0 and no flag register is built.
- Port list is identical in both builds.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, count=0, out_data=8'h00. Release -> no spurious push until the first sampled edge with rst_n=1.
- Fill/drain (WIDTH=8, DEPTH=4), out_ready=0:
  - Push 8'hA1, A2, A3, A4 -> count 1,2,3,4; in_ready=0 after 4th; out_data=A1.
  - Set out_ready=1 -> pops A1..A4 in order; out_valid=0 and count=0 after the 4th pop.
- Overflow: fill with 11,22,33,44, then in_valid=1 with 8'h55 for 1 cycle -> count stays 4, 55 never appears on out_data. overflow=1 with DFF_FIFO_OVERFLOW_FLAG_EN, 0 without; flag persists until rst_n pulse.
- Simultaneous push/pop: at count=2, drive in_valid=1 and out_ready=1 for 3 cycles with data 01,02,03 -> count stays 2, output order is the preceding words then 01,02,03.
- Wrap-around: 10 push/pop pairs of incrementing bytes 00..09 with count oscillating 0-3 -> pointers wrap at least twice, output sequence exactly 00..09.
- Async reset mid-stream: with count=3, pulse rst_n low for half a clock period between edges -> count=0 and out_valid=0 immediately, without waiting for a clock edge. Push 8'hEE after release -> out_data=EE.
